// File: rtl/display_scanner.sv
// display_scanner: walks every framebuffer pixel in raster order and issues one instruction per pixel
// over the Datapath start/finished handshake. Define CLEAR_PASS_EN to prepend a DRAW clear pass.
`ifndef INSTRUCTION_WIDTH
`define INSTRUCTION_WIDTH 32
`endif
`ifndef OPCODE_DRAW
`define OPCODE_DRAW 4'd1
`endif
`ifndef OPCODE_DISPLAY
`define OPCODE_DISPLAY 4'd2
`endif

module display_scanner #(
    parameter int unsigned SCREEN_W     = 160,
    parameter int unsigned SCREEN_H     = 120,
    parameter int unsigned INSTR_W      = `INSTRUCTION_WIDTH,
    parameter logic [2:0]  CLEAR_COLOUR = 3'd0
) (
    input  logic               clock,
    input  logic               resetn,
    input  logic               go,
    output logic               busy,
    output logic               frame_done,
    output logic               dp_start,
    output logic [INSTR_W-1:0] dp_instruction,
    input  logic               dp_finished
);

    localparam logic [7:0] X_LAST = 8'(SCREEN_W - 1);
    localparam logic [6:0] Y_LAST = 7'(SCREEN_H - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_ACK,
        S_WAIT,
        S_ADVANCE,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [7:0]         x_q, x_d;
    logic [6:0]         y_q, y_d;
    logic               busy_q, busy_d;
    logic               frame_done_q, frame_done_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic               clear_next;
`ifdef CLEAR_PASS_EN
    logic               pass_clear_q, pass_clear_d;
`endif

    function automatic logic [INSTR_W-1:0] make_instr(input logic [7:0] x, input logic [6:0] y,
                                                      input logic clear);
        logic [INSTR_W-1:0] instr;
        instr        = '0;
        instr[3:0]   = clear ? `OPCODE_DRAW : `OPCODE_DISPLAY;
        instr[11:4]  = x;
        instr[18:12] = y;
        instr[21:19] = clear ? CLEAR_COLOUR : 3'd0;
        instr[22]    = clear;
        return instr;
    endfunction

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
`ifdef CLEAR_PASS_EN
        pass_clear_d = pass_clear_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (go) begin
                    state_d = S_ISSUE;
                    x_d     = 8'd0;
                    y_d     = 7'd0;
`ifdef CLEAR_PASS_EN
                    pass_clear_d = 1'b1;
`endif
                end
            end
            S_ISSUE: begin
                if (dp_finished) begin
                    state_d = S_ACK;
                end
            end
            // Datapath drops finished only after seeing start, so its stale high is skipped here
            S_ACK: state_d = S_WAIT;
            S_WAIT: begin
                if (dp_finished) begin
                    state_d = S_ADVANCE;
                end
            end
            S_ADVANCE: begin
                if (x_q == X_LAST) begin
                    x_d = 8'd0;
                    if (y_q == Y_LAST) begin
                        y_d = 7'd0;
`ifdef CLEAR_PASS_EN
                        if (pass_clear_q) begin
                            pass_clear_d = 1'b0;
                            state_d      = S_ISSUE;
                        end else begin
                            state_d = S_DONE;
                        end
`else
                        state_d = S_DONE;
`endif
                    end else begin
                        y_d     = y_q + 7'd1;
                        state_d = S_ISSUE;
                    end
                end else begin
                    x_d     = x_q + 8'd1;
                    state_d = S_ISSUE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                x_d     = 8'd0;
                y_d     = 7'd0;
            end
            default: state_d = S_IDLE;
        endcase

`ifdef CLEAR_PASS_EN
        clear_next = pass_clear_d;
`else
        clear_next = 1'b0;
`endif

        busy_d       = (state_d != S_IDLE);
        frame_done_d = (state_q == S_DONE);
        if (state_d == S_IDLE) begin
            instr_d = '0;
        end else if (state_d == S_ISSUE) begin
            instr_d = make_instr(x_d, y_d, clear_next);
        end else begin
            instr_d = instr_q;
        end
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state_q      <= S_IDLE;
            x_q          <= 8'd0;
            y_q          <= 7'd0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
            instr_q      <= '0;
`ifdef CLEAR_PASS_EN
            pass_clear_q <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            x_q          <= x_d;
            y_q          <= y_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
            instr_q      <= instr_d;
`ifdef CLEAR_PASS_EN
            pass_clear_q <= pass_clear_d;
`endif
        end
    end

    // Start must fire in the same ISSUE cycle that sees finished, hence not registered
    assign dp_start       = resetn && (state_q == S_ISSUE) && dp_finished;
    assign busy           = busy_q;
    assign frame_done     = frame_done_q;
    assign dp_instruction = instr_q;

endmodule
